// File: rtl/flicky_hvgen_pkg.sv
// Shared timing constants and pipeline types for the Flicky video timing generator.
package flicky_hvgen_pkg;

    localparam int unsigned DEF_H_TOTAL     = 384;
    localparam int unsigned DEF_V_TOTAL     = 264;
    localparam int unsigned DEF_H_VIS       = 256;
    localparam int unsigned DEF_V_VIS       = 224;
    localparam int unsigned DEF_HSYNC_START = 304;
    localparam int unsigned DEF_HSYNC_LEN   = 32;
    localparam int unsigned DEF_VSYNC_START = 240;
    localparam int unsigned DEF_VSYNC_LEN   = 3;

    // One pixel's worth of registered video state, one pixel behind PH/PV.
    typedef struct packed {
        logic [7:0] pix;
        logic       hblank;
        logic       vblank;
        logic       hsync;
        logic       vsync;
    } pix_stage_t;

    function automatic logic [9:0] sext10(input logic [3:0] ofs);
        return {{6{ofs[3]}}, ofs};
    endfunction

endpackage

// File: rtl/flicky_rgb_expand.sv
// Expands the 8-bit {B2,G3,R3} palette pixel to 24-bit RGB and forces black during blanking.
module flicky_rgb_expand (
    input  logic [7:0] pix,
    input  logic       blank,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b
);

    logic [2:0] r3;
    logic [2:0] g3;
    logic [1:0] b2;

    always_comb begin
        r3 = pix[2:0];
        g3 = pix[5:3];
        b2 = pix[7:6];
        r  = '0;
        g  = '0;
        b  = '0;
        if (!blank) begin
            r = {r3, r3, r3[2:1]};
            g = {g3, g3, g3[2:1]};
            b = {b2, b2, b2, b2};
        end
    end

endmodule

// File: rtl/flicky_hvgen.sv
// Flicky video timing: 6 MHz pixel enable, H/V counters, offset-adjustable syncs and a one-pixel colour pipeline.
module flicky_hvgen
    import flicky_hvgen_pkg::*;
#(
    parameter int unsigned H_TOTAL     = DEF_H_TOTAL,
    parameter int unsigned V_TOTAL     = DEF_V_TOTAL,
    parameter int unsigned H_VIS       = DEF_H_VIS,
    parameter int unsigned V_VIS       = DEF_V_VIS,
    parameter int unsigned HSYNC_START = DEF_HSYNC_START,
    parameter int unsigned HSYNC_LEN   = DEF_HSYNC_LEN,
    parameter int unsigned VSYNC_START = DEF_VSYNC_START,
    parameter int unsigned VSYNC_LEN   = DEF_VSYNC_LEN
) (
    input  logic       clk48M,
    input  logic       reset,
    input  logic [3:0] HOFS,
    input  logic [3:0] VOFS,
    input  logic [7:0] POUT,
    output logic       CE_PIX,
    output logic [8:0] PH,
    output logic [8:0] PV,
    output logic [7:0] R,
    output logic [7:0] G,
    output logic [7:0] B,
    output logic       HSYNC,
    output logic       VSYNC,
    output logic       HBLANK,
    output logic       VBLANK
);

    logic [2:0] phase;
    logic [3:0] hofs_f;
    logic [3:0] vofs_f;
    pix_stage_t stage;

    logic       h_wrap;
    logic       v_wrap;
    logic [9:0] hs_lo;
    logic [9:0] hs_hi;
    logic [9:0] vs_lo;
    logic [9:0] vs_hi;
    logic       raw_hblank;
    logic       raw_vblank;
    logic       raw_hsync;
    logic       raw_vsync;

    // Gated by reset so the enable is low throughout reset, not just from the next edge.
    always_comb begin
        CE_PIX = (phase == 3'd7) && !reset;
    end

    always_comb begin
        h_wrap     = (PH == 9'(H_TOTAL - 1));
        v_wrap     = (PV == 9'(V_TOTAL - 1));
        hs_lo      = 10'(HSYNC_START) + sext10(hofs_f);
        hs_hi      = hs_lo + 10'(HSYNC_LEN - 1);
        vs_lo      = 10'(VSYNC_START) + sext10(vofs_f);
        vs_hi      = vs_lo + 10'(VSYNC_LEN - 1);
        raw_hblank = (PH >= 9'(H_VIS));
        raw_vblank = (PV >= 9'(V_VIS));
        raw_hsync  = ({1'b0, PH} >= hs_lo) && ({1'b0, PH} <= hs_hi);
        raw_vsync  = ({1'b0, PV} >= vs_lo) && ({1'b0, PV} <= vs_hi);
    end

    always_ff @(posedge clk48M) begin
        if (reset) begin
            phase  <= '0;
            PH     <= '0;
            PV     <= '0;
            hofs_f <= '0;
            vofs_f <= '0;
            stage  <= '0;
        end else begin
            phase <= phase + 3'd1;
            if (CE_PIX) begin
                stage <= '{pix:    POUT,
                           hblank: raw_hblank,
                           vblank: raw_vblank,
                           hsync:  raw_hsync,
                           vsync:  raw_vsync};
                if (h_wrap) begin
                    PH <= '0;
                    if (v_wrap) begin
                        PV     <= '0;
                        // Offsets only take effect at frame boundaries so a frame never tears.
                        hofs_f <= HOFS;
                        vofs_f <= VOFS;
                    end else begin
                        PV <= PV + 9'd1;
                    end
                end else begin
                    PH <= PH + 9'd1;
                end
            end
        end
    end

    always_comb begin
        HSYNC  = stage.hsync;
        VSYNC  = stage.vsync;
        HBLANK = stage.hblank;
        VBLANK = stage.vblank;
    end

    flicky_rgb_expand u_rgb_expand (
        .pix   (stage.pix),
        .blank (stage.hblank | stage.vblank),
        .r     (R),
        .g     (G),
        .b     (B)
    );

endmodule

// File: tb/tb_flicky_hvgen.sv
// Directed bench for flicky_hvgen on a reduced raster (48x20 total, 32x14 visible) to keep runs short.
module tb_flicky_hvgen;

    localparam int unsigned HT  = 48;
    localparam int unsigned VT  = 20;
    localparam int unsigned HV  = 32;
    localparam int unsigned VV  = 14;
    localparam int unsigned HSS = 36;
    localparam int unsigned HSL = 4;
    localparam int unsigned VSS = 16;
    localparam int unsigned VSL = 3;

    logic       clk48M = 1'b0;
    logic       reset;
    logic [3:0] HOFS;
    logic [3:0] VOFS;
    logic [7:0] POUT;
    logic       CE_PIX;
    logic [8:0] PH;
    logic [8:0] PV;
    logic [7:0] R;
    logic [7:0] G;
    logic [7:0] B;
    logic       HSYNC;
    logic       VSYNC;
    logic       HBLANK;
    logic       VBLANK;

    int checks   = 0;
    int failures = 0;

    always #5 clk48M = ~clk48M;

    flicky_hvgen #(
        .H_TOTAL     (HT),
        .V_TOTAL     (VT),
        .H_VIS       (HV),
        .V_VIS       (VV),
        .HSYNC_START (HSS),
        .HSYNC_LEN   (HSL),
        .VSYNC_START (VSS),
        .VSYNC_LEN   (VSL)
    ) dut (
        .clk48M (clk48M),
        .reset  (reset),
        .HOFS   (HOFS),
        .VOFS   (VOFS),
        .POUT   (POUT),
        .CE_PIX (CE_PIX),
        .PH     (PH),
        .PV     (PV),
        .R      (R),
        .G      (G),
        .B      (B),
        .HSYNC  (HSYNC),
        .VSYNC  (VSYNC),
        .HBLANK (HBLANK),
        .VBLANK (VBLANK)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk48M);
    endtask

    // Leaves the bench at the negedge just before the CE_PIX edge for pixel (ph, pv).
    task automatic goto_ce(input int ph, input int pv);
        int budget;
        budget = 20000;
        @(negedge clk48M);
        while (!(CE_PIX === 1'b1 && PH == 9'(ph) && PV == 9'(pv)) && budget > 0) begin
            @(negedge clk48M);
            budget--;
        end
        check_eq($sformatf("goto_%0d_%0d", ph, pv), {CE_PIX, PH, PV}, {1'b1, 9'(ph), 9'(pv)});
    endtask

    task automatic measure_hs(output int first_ph, output int cyc);
        first_ph = -1;
        cyc      = 0;
        repeat (HT * 8) begin
            @(negedge clk48M);
            if (HSYNC === 1'b1) begin
                cyc++;
                if (first_ph < 0) first_ph = int'(PH);
            end
        end
    endtask

    initial begin
        int pulses, bad_space, last_ce, first_ce, ph_max, pv_max;
        int hwraps, frames, bad_pv, prev_ph, prev_pv;
        int hs_first, hs_cyc, vs_pv, vs_ph, vs_cyc;

        reset = 1'b1;
        HOFS  = 4'd0;
        VOFS  = 4'd0;
        POUT  = 8'h00;
        step(4);
        check_eq("rst_counters", {PH, PV}, 18'd0);
        check_eq("rst_ce", CE_PIX, 1'b0);
        check_eq("rst_rgb", {R, G, B}, 24'd0);
        check_eq("rst_sync_blank", {HSYNC, VSYNC, HBLANK, VBLANK}, 4'd0);

        // 8000 cycles after release: 1000 pixels = 20 lines + 40 pixels, exactly one frame wrap.
        reset     = 1'b0;
        pulses    = 0;
        bad_space = 0;
        last_ce   = -1;
        first_ce  = -1;
        ph_max    = 0;
        pv_max    = 0;
        hwraps    = 0;
        frames    = 0;
        bad_pv    = 0;
        prev_ph   = 0;
        prev_pv   = 0;
        for (int n = 1; n <= 8000; n++) begin
            @(negedge clk48M);
            if (CE_PIX === 1'b1) begin
                pulses++;
                if (first_ce < 0) first_ce = n;
                if (last_ce >= 0 && n - last_ce != 8) bad_space++;
                last_ce = n;
            end
            if (int'(PH) > ph_max) ph_max = int'(PH);
            if (int'(PV) > pv_max) pv_max = int'(PV);
            if (prev_ph == HT - 1 && PH == 9'd0) begin
                hwraps++;
                if (int'(PV) != (prev_pv + 1) % VT) bad_pv++;
                if (prev_pv == VT - 1) frames++;
            end
            prev_ph = int'(PH);
            prev_pv = int'(PV);
        end
        check_eq("ce_count", pulses, 1000);
        check_eq("ce_first", first_ce, 7);
        check_eq("ce_spacing_bad", bad_space, 0);
        check_eq("ph_max", ph_max, HT - 1);
        check_eq("pv_max", pv_max, VT - 1);
        check_eq("line_wraps", hwraps, 20);
        check_eq("pv_step_bad", bad_pv, 0);
        check_eq("frame_wraps", frames, 1);
        check_eq("end_pos", {PH, PV}, {9'd40, 9'd0});

        goto_ce(0, 3);
        measure_hs(hs_first, hs_cyc);
        check_eq("hs_first_ph", hs_first, HSS + 1);
        check_eq("hs_width_clk", hs_cyc, HSL * 8);

        goto_ce(0, 10);
        vs_pv  = -1;
        vs_ph  = -1;
        vs_cyc = 0;
        repeat (10 * HT * 8) begin
            @(negedge clk48M);
            if (VSYNC === 1'b1) begin
                vs_cyc++;
                if (vs_pv < 0) begin
                    vs_pv = int'(PV);
                    vs_ph = int'(PH);
                end
            end
        end
        check_eq("vs_first_pv", vs_pv, VSS);
        check_eq("vs_first_ph", vs_ph, 1);
        check_eq("vs_width_clk", vs_cyc, VSL * HT * 8);

        POUT = 8'hFF;
        goto_ce(10, 5);
        step(1);
        check_eq("px_ff", {R, G, B}, 24'hFFFFFF);
        POUT = 8'h05;
        goto_ce(11, 5);
        step(1);
        check_eq("px_05", {R, G, B}, 24'hB60000);
        POUT = 8'hFF;
        goto_ce(HV - 1, 5);
        step(1);
        check_eq("last_vis_hblank", HBLANK, 1'b0);
        check_eq("last_vis_rgb", {R, G, B}, 24'hFFFFFF);
        goto_ce(HV, 5);
        step(1);
        check_eq("first_hblank", HBLANK, 1'b1);
        check_eq("hblank_rgb", {R, G, B}, 24'd0);
        goto_ce(5, VV - 1);
        step(1);
        check_eq("last_vis_vblank", VBLANK, 1'b0);
        check_eq("last_vis_line_rgb", {R, G, B}, 24'hFFFFFF);
        goto_ce(0, VV);
        step(1);
        check_eq("first_vblank", VBLANK, 1'b1);
        check_eq("vblank_rgb0", {R, G, B}, 24'd0);
        goto_ce(20, VV);
        step(1);
        check_eq("vblank_rgb20", {R, G, B}, 24'd0);

        // Offset changed mid-frame: current frame keeps 0, next frame moves sync 8 pixels earlier.
        HOFS = 4'b1000;
        goto_ce(0, 15);
        measure_hs(hs_first, hs_cyc);
        check_eq("hofs_same_frame", hs_first, HSS + 1);
        goto_ce(0, 3);
        measure_hs(hs_first, hs_cyc);
        check_eq("hofs_next_frame", hs_first, HSS - 8 + 1);
        check_eq("hofs_width_clk", hs_cyc, HSL * 8);

        goto_ce(HSS + 2, VSS);
        step(1);
        check_eq("pre_rst_flags", {HSYNC, VSYNC, HBLANK, VBLANK}, 4'b0111);
        goto_ce(HSS - 8 + 2, VSS);
        step(1);
        check_eq("pre_rst_hs", HSYNC, 1'b1);
        reset = 1'b1;
        step(1);
        check_eq("mid_rst_counters", {PH, PV}, 18'd0);
        check_eq("mid_rst_ce", CE_PIX, 1'b0);
        check_eq("mid_rst_outs", {R, G, B, HSYNC, VSYNC, HBLANK, VBLANK}, 28'd0);
        step(2);
        reset = 1'b0;
        step(7);
        check_eq("post_rst_ce", {CE_PIX, PH, PV}, {1'b1, 9'd0, 9'd0});
        step(1);
        check_eq("post_rst_adv", {CE_PIX, PH, PV}, {1'b0, 9'd1, 9'd0});
        measure_hs(hs_first, hs_cyc);
        check_eq("post_rst_hofs0", hs_first, HSS + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/flicky_hvgen.md
FLICKY_HVGEN -- requirements
Module: flicky_hvgen

Interface
REQ-001 Parameter H_TOTAL, 384, pixel clocks per line.
REQ-002 Parameter V_TOTAL, 264, lines per frame.
REQ-003 Parameter H_VIS, 256, active pixels per line.
REQ-004 Parameter V_VIS, 224, active lines per frame.
REQ-005 clk48M  in  1  sole clock (48 MHz); one clock, all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 HOFS  in  4  signed horizontal sync offset, -8..+7 pixels.
REQ-008 VOFS  in  4  signed vertical sync offset, -8..+7 lines.
REQ-009 POUT  in  8  palette pixel from video core, {B[1:0],G[2:0],R[2:0]}.
REQ-010 CE_PIX  out  1  one-clk48M-cycle pixel enable, 6 MHz rate.
REQ-011 PH  out  9  horizontal pixel counter fed to video core.
REQ-012 PV  out  9  vertical line counter fed to video core.
REQ-013 R, G, B  out  8 each  expanded colour, blank-forced.
REQ-014 HSYNC, VSYNC  out  1 each  active-high sync.
REQ-015 HBLANK, VBLANK  out  1 each  active-high blank, aligned with R/G/B.

Function
REQ-016 3-bit phase counter increments every clk48M; CE_PIX SHALL be high exactly when phase = 7 (one cycle in eight).
REQ-017 PH SHALL advance only on CE_PIX, counting 0..H_TOTAL-1, then wrap to 0.
REQ-018 PV SHALL advance on the CE_PIX where PH wraps, counting 0..V_TOTAL-1, then wrap to 0; PH and PV wrap on the same edge at frame end.
REQ-019 Raw hblank = (PH >= H_VIS); raw vblank = (PV >= V_VIS).
REQ-020 HSYNC SHALL be high while PH in [304+HOFS_f, 335+HOFS_f] (32 pixels); VSYNC high while PV in [240+VOFS_f, 242+VOFS_f] (3 lines); bounds computed sign-extended to 10 bits.
REQ-021 HOFS_f/VOFS_f SHALL be captured from HOFS/VOFS only on the CE_PIX where PH and PV both wrap to 0; mid-frame changes SHALL not affect the current frame.
REQ-022 Pixel pipeline: on CE_PIX, POUT and raw blanks SHALL be registered; R/G/B, HBLANK, VBLANK SHALL therefore lag PH/PV by exactly one pixel; HSYNC/VSYNC SHALL be delayed identically.
REQ-023 Expansion: R = {r,r,r[2:1]}, G = {g,g,g[2:1]}, B = {b,b,b,b}.
REQ-024 R/G/B SHALL be 0 whenever registered HBLANK or VBLANK is high.
REQ-025 All outputs other than CE_PIX SHALL change only on the cycle following CE_PIX.
REQ-026 Line rate = 6 MHz / 384 = 15.625 kHz; frame = 264 lines (~59.19 Hz).

Reset
REQ-027 While reset high: phase, PH, PV = 0; HOFS_f, VOFS_f = 0; R/G/B = 0; HSYNC, VSYNC = 0; HBLANK, VBLANK = 0; CE_PIX = 0.
REQ-028 Reset asserted mid-line SHALL abort the frame; first CE_PIX after release occurs 8 cycles later with PH advancing to 1.
REQ-029 First frame after reset SHALL use offsets sampled at the first wrap; until then offsets = 0.

Structure
REQ-030 Shared package holds H_TOTAL, V_TOTAL, H_VIS, V_VIS defaults, HSYNC_START=304, HSYNC_LEN=32, VSYNC_START=240, VSYNC_LEN=3.
REQ-031 One sub-module, flicky_rgb_expand (combinational 8-bit to 24-bit expansion plus blank gating); counters and pipeline stay in flicky_hvgen.

Verification
REQ-032 Release reset, run 8000 clk48M -> CE_PIX pulses exactly 1000, spacing 8; PH=0→383 wraps, PV increments once per 384 pixels.
REQ-033 Full frame, HOFS=0, VOFS=0 -> HSYNC high PH 305..336 (one-pixel lag), width 256 clk48M; VSYNC 3 lines from line 240; 264 lines/frame.
REQ-034 POUT=8'hFF at PH=10, PV=5 -> R=G=B=8'hFF on next pixel; POUT=8'h05 -> R=8'hB6, G=8'h00, B=8'h00.
REQ-035 POUT=8'hFF held, PH=256 -> HBLANK=1 and RGB=0 one pixel later; PV=224 -> VBLANK=1, RGB=0 all line.
REQ-036 HOFS changed from 0 to -8 at PV=100 -> current frame HSYNC unchanged; next frame HSYNC starts PH 296 (+1 lag).
REQ-037 Assert reset at PH=200, PV=50 for 3 cycles -> all outputs 0 next cycle; counting restarts from PH=0, PV=0.
